// File: rtl/conv_tile_sequencer.sv
// rtl/conv_tile_sequencer.sv - byte-stream tile sequencer for the 3x3/2x2 systolic conv array
module conv_tile_sequencer #(
  parameter int ARRAY_LATENCY = 3,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cfg_reuse_weights,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic [71:0]       arr_act,
  output logic [31:0]       arr_wgt,
  input  logic [127:0]      arr_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  tile_count,
  output logic              wgt_loaded
);

  localparam int LAT_W = (ARRAY_LATENCY < 1) ? 1 : $clog2(ARRAY_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_A,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        idx;
  logic [LAT_W-1:0]  cnt;
  logic [8:0][7:0]   act_q;
  logic [3:0][7:0]   wgt_q;
  logic [3:0][31:0]  res_buf;

  assign arr_act = act_q;
  assign arr_wgt = wgt_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = (state != S_IDLE);
    out_data  = res_buf[idx[1:0]];
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (cfg_reuse_weights && wgt_loaded) ? S_LOAD_A : S_LOAD_W;
      end
      S_LOAD_W: begin
        in_ready = 1'b1;
        if (in_valid && idx == 4'd3) state_nxt = S_LOAD_A;
      end
      S_LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid && idx == 4'd8) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == '0) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_last  = (idx == 4'd3);
        if (out_ready && idx == 4'd3) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers; everything outside the active load/drain state holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      cnt        <= '0;
      act_q      <= '0;
      wgt_q      <= '0;
      res_buf    <= '0;
      tile_count <= '0;
      wgt_loaded <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !(cfg_reuse_weights && wgt_loaded)) wgt_loaded <= 1'b0;
        end
        S_LOAD_W: begin
          if (in_valid) begin
            wgt_q[idx[1:0]] <= in_data;
            if (idx == 4'd3) begin
              idx        <= '0;
              wgt_loaded <= 1'b1;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        S_LOAD_A: begin
          if (in_valid) begin
            act_q[idx] <= in_data;
            if (idx == 4'd8) begin
              idx <= '0;
              cnt <= LAT_W'(ARRAY_LATENCY);
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            res_buf <= arr_result;
            idx     <= '0;
          end else begin
            cnt <= cnt - LAT_W'(1);
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (idx == 4'd3) begin
              idx        <= '0;
              tile_count <= tile_count + CNT_W'(1);
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        default: idx <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// tb/tb_conv_tile_sequencer.sv - directed self-checking bench for conv_tile_sequencer
module tb_conv_tile_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         cfg_reuse_weights;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic [71:0]  arr_act;
  logic [31:0]  arr_wgt;
  logic [127:0] arr_result;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         busy;
  logic [15:0]  tile_count;
  logic         wgt_loaded;

  int n_cmp = 0;
  int n_bad = 0;
  logic corrupt = 1'b0;

  conv_tile_sequencer #(.ARRAY_LATENCY(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_reuse_weights(cfg_reuse_weights),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .arr_act(arr_act), .arr_wgt(arr_wgt), .arr_result(arr_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .tile_count(tile_count), .wgt_loaded(wgt_loaded)
  );

  always #5 clk = ~clk;

  // Behavioural array: 2x2 valid convolution; garbage while corrupt to prove buffer isolation.
  always_comb begin
    logic [31:0] sum;
    arr_result = '0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        sum = '0;
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++)
            sum = sum + 32'(arr_act[8*((r+i)*3+c+j) +: 8]) * 32'(arr_wgt[8*(i*2+j) +: 8]);
        arr_result[32*(r*2+c) +: 32] = sum;
      end
    end
    if (corrupt) arr_result = {4{32'hDEAD_BEEF}};
  end

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_start(input logic reuse);
    start = 1'b1;
    cfg_reuse_weights = reuse;
    @(negedge clk);
    start = 1'b0;
    cfg_reuse_weights = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (!in_ready) begin
      n_bad++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_kernel(input logic [7:0] w0, w1, w2, w3);
    send_byte(w0, 0); send_byte(w1, 0); send_byte(w2, 0); send_byte(w3, 0);
  endtask

  task automatic send_img_seq(input int gap_mode);
    for (int i = 1; i <= 9; i++) send_byte(8'(i), (gap_mode != 0) ? (i % 3) : 0);
  endtask

  task automatic recv_tile(input logic [31:0] e0, e1, e2, e3, input int stall_mode,
                           input logic [15:0] exp_tiles);
    logic [31:0] e [4];
    logic [31:0] held;
    logic        held_v;
    int k, t;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    k = 0; t = 0; held_v = 1'b0; held = '0;
    while (k < 4 && t < 200) begin
      out_ready = (stall_mode == 0) || (t % 3 == 0);
      if (out_valid) begin
        corrupt = 1'b1;
        if (held_v) begin
          n_cmp++;
          if (out_data !== held) begin
            n_bad++;
            $display("FAIL stall_stable: out_data=%0h required %0h", out_data, held);
          end
        end
        if (out_ready) begin
          n_cmp++;
          if (out_data !== e[k] || out_last !== (k == 3)) begin
            n_bad++;
            $display("FAIL result%0d: data=%0d last=%0b required data=%0d last=%0b",
                     k, out_data, out_last, e[k], (k == 3));
          end
          k++;
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held   = out_data;
        end
      end
      @(negedge clk);
      t++;
    end
    out_ready = 1'b0;
    corrupt = 1'b0;
    n_cmp++;
    if (k != 4) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d results required 4", k);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || tile_count !== exp_tiles) begin
      n_bad++;
      $display("FAIL tile_end: out_valid=%0b busy=%0b tile_count=%0d required 0 0 %0d",
               out_valid, busy, tile_count, exp_tiles);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        out_data !== 32'd0 || tile_count !== 16'd0 || wgt_loaded !== 1'b0 ||
        arr_act !== 72'd0 || arr_wgt !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%0b in_ready=%0b out_valid=%0b last=%0b data=%0h tiles=%0d wl=%0b act=%0h wgt=%0h required all 0",
               busy, in_ready, out_valid, out_last, out_data, tile_count, wgt_loaded, arr_act, arr_wgt);
    end
  endtask

  task automatic test_basic();
    do_start(1'b0);
    send_kernel(8'd1, 8'd0, 8'd0, 8'd1);
    send_img_seq(0);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL wait_phase: out_valid=%0b busy=%0b required 0 1", out_valid, busy);
    end
    recv_tile(32'd6, 32'd8, 32'd12, 32'd14, 0, 16'd1);
    n_cmp++;
    if (wgt_loaded !== 1'b1) begin
      n_bad++;
      $display("FAIL wgt_loaded_basic: %0b required 1", wgt_loaded);
    end
  endtask

  task automatic test_reuse();
    do_start(1'b1);
    send_img_seq(0);
    recv_tile(32'd6, 32'd8, 32'd12, 32'd14, 0, 16'd2);
    do_start(1'b0);
    send_kernel(8'd1, 8'd1, 8'd1, 8'd1);
    send_img_seq(0);
    recv_tile(32'd12, 32'd16, 32'd24, 32'd28, 0, 16'd3);
  endtask

  task automatic test_all_ff();
    do_start(1'b0);
    send_kernel(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    for (int i = 0; i < 9; i++) send_byte(8'hFF, 0);
    recv_tile(32'h0003F804, 32'h0003F804, 32'h0003F804, 32'h0003F804, 0, 16'd4);
  endtask

  task automatic test_back_to_back_stall();
    do_start(1'b0);
    send_byte(8'd1, 2); send_byte(8'd1, 0); send_byte(8'd1, 1); send_byte(8'd1, 3);
    send_img_seq(1);
    recv_tile(32'd12, 32'd16, 32'd24, 32'd28, 1, 16'd5);
  endtask

  task automatic test_reset_mid_tile();
    do_start(1'b1);
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 0);
    do_reset();
    n_cmp++;
    if (busy !== 1'b0 || wgt_loaded !== 1'b0 || tile_count !== 16'd0 || arr_act !== 72'd0) begin
      n_bad++;
      $display("FAIL reset_mid: busy=%0b wl=%0b tiles=%0d act=%0h required 0 0 0 0",
               busy, wgt_loaded, tile_count, arr_act);
    end
    do_start(1'b1);
    send_kernel(8'd2, 8'd0, 8'd0, 8'd0);
    send_img_seq(0);
    recv_tile(32'd2, 32'd4, 32'd8, 32'd10, 0, 16'd1);
  endtask

  task automatic test_start_ignored();
    int t;
    do_start(1'b0);
    send_kernel(8'd1, 8'd0, 8'd0, 8'd1);
    for (int i = 1; i <= 3; i++) send_byte(8'(i), 0);
    do_start(1'b1);
    for (int i = 4; i <= 9; i++) send_byte(8'(i), 0);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    do_start(1'b0);
    recv_tile(32'd6, 32'd8, 32'd12, 32'd14, 0, 16'd2);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL start_ignored_idle: busy=%0b required 0", busy);
    end
    do_reset();
    do_start(1'b1);
    send_byte(8'd1, 0); send_byte(8'd1, 0); send_byte(8'd1, 0);
    n_cmp++;
    if (wgt_loaded !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL forced_load_w: wl=%0b in_ready=%0b required 0 1", wgt_loaded, in_ready);
    end
    send_byte(8'd1, 0);
    n_cmp++;
    if (wgt_loaded !== 1'b1) begin
      n_bad++;
      $display("FAIL forced_load_w_done: wl=%0b required 1", wgt_loaded);
    end
    send_img_seq(0);
    recv_tile(32'd12, 32'd16, 32'd24, 32'd28, 0, 16'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_reuse_weights = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_reuse();
    test_all_ff();
    test_back_to_back_stall();
    test_reset_mid_tile();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
